e203_exu_flush_arb: RTL and testbench
=====================================

Name: e203_exu_flush_arb

Overview:
- Parametrised successor to the two-source commit flush merge: arbitrates NSRC pipeline-flush requesters onto the single IFU flush interface.
- Locks the winner until pipe_flush_ack and returns a per-source ack.
- Buffers resolved-branch records in a BHT writeback FIFO.
- Keeps per-source saturating flush counters for performance analysis.
- Sits between the EXU flush generators (exception/IRQ, branch resolve, future sources) and the IFU/BHT.

Parameters:
- NSRC, 2, number of flush sources; index 0 has the highest priority.
- PCW, 32, PC / adder-operand width.
- DEPTH, 4, BHT writeback FIFO entries; power of two, at least 2.
- CNTW, 16, width of each flush counter.
- PREEMPT, 0, 1 = a higher-priority request may replace a pending, un-acked grant.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_req  in  NSRC  flush request per source
- src_add_op1  in  NSRC*PCW  per-source adder op1, packed, source i at [i*PCW +: PCW]
- src_add_op2  in  NSRC*PCW  per-source adder op2, packed
- src_pc  in  NSRC*PCW  per-source flush PC (timing-boost path), packed
- src_ack  out  NSRC  one-hot: granted source was accepted this cycle
- pipe_flush_req  out  1  flush request to IFU
- pipe_flush_add_op1  out  PCW  selected op1
- pipe_flush_add_op2  out  PCW  selected op2
- pipe_flush_pc  out  PCW  selected PC
- pipe_flush_src  out  NSRC  one-hot current grant; 0 when no request
- pipe_flush_ack  in  1  IFU accept
- flush_pulse  out  1  pipe_flush_req & pipe_flush_ack
- cmt_valid  in  1  branch-resolve record valid
- cmt_ready  out  1  FIFO can accept
- cmt_prdt  in  1  predicted taken
- cmt_rslv  in  1  resolved taken
- cmt_pc  in  PCW  branch PC
- bht_wb_valid  out  1  FIFO head valid
- bht_wb_ready  in  1  BHT accepts head
- bht_wb_mis  out  1  head mispredict (prdt != rslv)
- bht_wb_prdt  out  1  head predicted
- bht_wb_rslv  out  1  head resolved
- bht_wb_pc  out  PCW  head PC
- cnt_clr  in  1  clear all counters
- cnt_sel  in  $clog2(NSRC) (min 1)  counter read index
- cnt_rd  out  CNTW  selected counter value

Behaviour:
- Reset: lock clear, FIFO empty, all counters 0. Outputs: src_ack=0, pipe_flush_req=0, pipe_flush_src=0, flush_pulse=0, bht_wb_valid=0, cmt_ready=1, cnt_rd=0. Data outputs are 0 when no grant or FIFO empty.
- Reset mid-handshake: drops the lock and discards FIFO contents.
- Flush path has zero latency: request to pipe_flush_req is combinational in the same cycle.
- Idle (unlocked): grant = lowest asserted src_req index. pipe_flush_req = |src_req. Operands and PC are muxed from the grant.
- Grant accepted (pipe_flush_ack=1 in the same cycle):
  - flush_pulse=1 and src_ack[grant]=1; state stays unlocked.
  - Next cycle re-arbitrates from the remaining requests.
- Grant not acked: register lock_vld=1, lock_idx=grant.
  - While locked with PREEMPT=0: output stays on lock_idx regardless of higher-priority requests.
  - While locked with PREEMPT=1: grant = lowest asserted index overall, and the lock updates to it.
- Lock release: pipe_flush_ack while locked, or src_req[lock_idx] deasserted. Deassertion is a protocol violation; the lock is released and arbitration is combinational that cycle.
- Sources hold req and operands stable until src_ack.
- Counters:
  - On flush_pulse, counter[grant] += 1, saturating at 2^CNTW-1.
  - cnt_clr has priority over an increment in the same cycle.
  - cnt_rd is registered: value of counter[cnt_sel] one cycle later.
  - cnt_sel >= NSRC reads 0.
- FIFO:
  - push = cmt_valid & cmt_ready; cmt_ready = ~full. No same-cycle bypass, and no push when full even if popping.
  - pop = bht_wb_valid & bht_wb_ready.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointers are log2(DEPTH)+1 bits with wrap bit. Empty = pointers equal; full = MSB differs and rest equal.
  - Head outputs come directly from the storage array at rd_ptr; bht_wb_mis = prdt ^ rslv.
- Assertion (sim only): $onehot0(pipe_flush_src); warning on req-drop while locked.

Decomposition:
- Package e203_flush_pkg: bht record struct {prdt, rslv, pc}, default PCW/CNTW constants, one-hot-to-index function.
- Sub-module e203_bht_wb_fifo, a parametrised DEPTH x record FIFO with valid/ready on both sides.
- Arbiter, lock and counters stay in the top module.

Test Plan:
- src_req=2'b11, ack=1 in the same cycle -> pipe_flush_src=01, src_ack=01, flush_pulse=1, counter0=1; next cycle src1 granted.
- PREEMPT=0: src_req=10, no ack 3 cycles, then src0 rises -> output stays source 1 until ack; src_ack=10, then source 0.
- PREEMPT=1, same stimulus -> grant switches to source 0 the cycle src0 rises; op1/op2/pc follow.
- Push 4 records with bht_wb_ready=0 (DEPTH=4) -> cmt_ready=0 after the 4th. Pop order matches push. Record prdt=1, rslv=0 gives bht_wb_mis=1.
- CNTW=2: 5 acked flushes on source 1 -> cnt_rd saturates at 3. cnt_clr and a flush in the same cycle -> 0.
- rst asserted while locked with 2 FIFO entries -> next cycle pipe_flush_req=0, bht_wb_valid=0, cmt_ready=1.

Source files
------------

// File: rtl/e203_flush_pkg.sv
// Shared types and helpers for the EXU flush arbiter and its BHT writeback FIFO.
package e203_flush_pkg;

    localparam int unsigned DEF_PCW  = 32;
    localparam int unsigned DEF_CNTW = 16;
    localparam int unsigned MAX_SRC  = 32;

    typedef struct packed {
        logic               prdt;
        logic               rslv;
        logic [DEF_PCW-1:0] pc;
    } bht_rec_t;

    // Index of the single set bit; callers guarantee at most one bit is set.
    function automatic int unsigned onehot_to_idx(input logic [MAX_SRC-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/e203_bht_wb_fifo.sv
// DEPTH x W record FIFO with valid/ready on both ends; head read straight from storage.
module e203_bht_wb_fifo
    import e203_flush_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = $bits(bht_rec_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;

    // Wrap bit distinguishes full from empty when the index bits match.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        in_ready  = ~full;
        out_valid = ~empty;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

endmodule

// File: rtl/e203_exu_flush_arb.sv
// Arbitrates NSRC pipeline-flush sources onto the IFU flush port, buffers
// branch-resolve records for BHT writeback and counts flushes per source.
module e203_exu_flush_arb
    import e203_flush_pkg::*;
#(
    parameter int unsigned NSRC    = 2,
    parameter int unsigned PCW     = DEF_PCW,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNTW    = DEF_CNTW,
    parameter int unsigned PREEMPT = 0,
    localparam int unsigned SELW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     src_req,
    input  logic [NSRC*PCW-1:0] src_add_op1,
    input  logic [NSRC*PCW-1:0] src_add_op2,
    input  logic [NSRC*PCW-1:0] src_pc,
    output logic [NSRC-1:0]     src_ack,
    output logic                pipe_flush_req,
    output logic [PCW-1:0]      pipe_flush_add_op1,
    output logic [PCW-1:0]      pipe_flush_add_op2,
    output logic [PCW-1:0]      pipe_flush_pc,
    output logic [NSRC-1:0]     pipe_flush_src,
    input  logic                pipe_flush_ack,
    output logic                flush_pulse,
    input  logic                cmt_valid,
    output logic                cmt_ready,
    input  logic                cmt_prdt,
    input  logic                cmt_rslv,
    input  logic [PCW-1:0]      cmt_pc,
    output logic                bht_wb_valid,
    input  logic                bht_wb_ready,
    output logic                bht_wb_mis,
    output logic                bht_wb_prdt,
    output logic                bht_wb_rslv,
    output logic [PCW-1:0]      bht_wb_pc,
    input  logic                cnt_clr,
    input  logic [SELW-1:0]     cnt_sel,
    output logic [CNTW-1:0]     cnt_rd
);

    logic            lock_vld;
    logic [SELW-1:0] lock_idx;
    logic            lock_live;
    logic            req_any;
    logic [NSRC-1:0] prio_oh;
    logic [SELW-1:0] prio_idx;
    logic [SELW-1:0] grant_idx;
    logic [NSRC-1:0] grant_oh;
    logic [CNTW-1:0] cnt_q [NSRC];
    logic [CNTW-1:0] rd_nxt;
    logic [PCW+1:0]  fifo_out;

    // Lock register: held while a grant waits for the IFU to accept it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock_vld <= req_any & ~pipe_flush_ack;
            lock_idx <= grant_idx;
        end
    end

    // Grant selection: a live lock wins unless preemption lets priority take over.
    always_comb begin
        req_any   = |src_req;
        prio_oh   = src_req & (~src_req + NSRC'(1));
        prio_idx  = SELW'(onehot_to_idx(MAX_SRC'(prio_oh)));
        lock_live = lock_vld & src_req[lock_idx];
        grant_idx = (lock_live && (PREEMPT == 0)) ? lock_idx : prio_idx;
        grant_oh  = '0;
        if (req_any) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        pipe_flush_req     = req_any;
        pipe_flush_src     = grant_oh;
        flush_pulse        = req_any & pipe_flush_ack;
        src_ack            = flush_pulse ? grant_oh : '0;
        pipe_flush_add_op1 = '0;
        pipe_flush_add_op2 = '0;
        pipe_flush_pc      = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant_oh[i]) begin
                pipe_flush_add_op1 = pipe_flush_add_op1 | src_add_op1[i*PCW +: PCW];
                pipe_flush_add_op2 = pipe_flush_add_op2 | src_add_op2[i*PCW +: PCW];
                pipe_flush_pc      = pipe_flush_pc      | src_pc[i*PCW +: PCW];
            end
        end
    end

    // Saturating per-source flush counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int unsigned i = 0; i < NSRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (src_ack[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNTW'(1);
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (SELW'(i) == cnt_sel) rd_nxt = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_rd <= '0;
        else     cnt_rd <= rd_nxt;
    end

    e203_bht_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (PCW + 2)
    ) u_bht_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cmt_valid),
        .in_ready  (cmt_ready),
        .in_data   ({cmt_prdt, cmt_rslv, cmt_pc}),
        .out_valid (bht_wb_valid),
        .out_ready (bht_wb_ready),
        .out_data  (fifo_out)
    );

    always_comb begin
        bht_wb_prdt = fifo_out[PCW+1];
        bht_wb_rslv = fifo_out[PCW];
        bht_wb_pc   = fifo_out[PCW-1:0];
        bht_wb_mis  = fifo_out[PCW+1] ^ fifo_out[PCW];
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(pipe_flush_src));

    a_lock_req_held: assert property (@(posedge clk) disable iff (rst) !(lock_vld && !src_req[lock_idx]))
        else $warning("flush source %0d dropped its request while locked", lock_idx);

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Scoreboard bench: stimulus queues expected flush/BHT responses, monitors pop and compare.
module tb_e203_exu_flush_arb;
    import e203_flush_pkg::*;

    typedef struct packed {
        logic [1:0]  src;
        logic [1:0]  ack;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
    } fexp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  src_req, src_req_b;
    logic        ack, ack_b;
    logic [63:0] src_add_op1, src_add_op2, src_pc;
    logic        cmt_valid, cmt_prdt, cmt_rslv;
    logic [31:0] cmt_pc;
    logic        bht_wb_ready, cnt_clr;
    logic [0:0]  cnt_sel;

    logic [1:0]  src_ack, pipe_flush_src;
    logic        pipe_flush_req, flush_pulse, cmt_ready;
    logic [31:0] pipe_flush_add_op1, pipe_flush_add_op2, pipe_flush_pc, bht_wb_pc;
    logic        bht_wb_valid, bht_wb_mis, bht_wb_prdt, bht_wb_rslv;
    logic [1:0]  cnt_rd;

    logic [1:0]  b_src_ack, b_src;
    logic        b_req, b_pulse, b_cmt_ready, b_wb_valid, b_wb_mis, b_wb_prdt, b_wb_rslv;
    logic [31:0] b_op1, b_op2, b_pc, b_wb_pc;
    logic [15:0] b_cnt_rd;

    int n_vec = 0;
    int n_err = 0;
    fexp_t    qa[$];
    fexp_t    qb[$];
    bht_rec_t qbht[$];

    e203_exu_flush_arb #(.NSRC(2), .PCW(32), .DEPTH(4), .CNTW(2), .PREEMPT(0)) u_dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_add_op1(src_add_op1),
        .src_add_op2(src_add_op2), .src_pc(src_pc), .src_ack(src_ack),
        .pipe_flush_req(pipe_flush_req), .pipe_flush_add_op1(pipe_flush_add_op1),
        .pipe_flush_add_op2(pipe_flush_add_op2), .pipe_flush_pc(pipe_flush_pc),
        .pipe_flush_src(pipe_flush_src), .pipe_flush_ack(ack), .flush_pulse(flush_pulse),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_prdt(cmt_prdt), .cmt_rslv(cmt_rslv),
        .cmt_pc(cmt_pc), .bht_wb_valid(bht_wb_valid), .bht_wb_ready(bht_wb_ready),
        .bht_wb_mis(bht_wb_mis), .bht_wb_prdt(bht_wb_prdt), .bht_wb_rslv(bht_wb_rslv),
        .bht_wb_pc(bht_wb_pc), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
    );

    e203_exu_flush_arb #(.NSRC(2), .PCW(32), .DEPTH(4), .CNTW(16), .PREEMPT(1)) u_dut_pre (
        .clk(clk), .rst(rst), .src_req(src_req_b), .src_add_op1(src_add_op1),
        .src_add_op2(src_add_op2), .src_pc(src_pc), .src_ack(b_src_ack),
        .pipe_flush_req(b_req), .pipe_flush_add_op1(b_op1),
        .pipe_flush_add_op2(b_op2), .pipe_flush_pc(b_pc),
        .pipe_flush_src(b_src), .pipe_flush_ack(ack_b), .flush_pulse(b_pulse),
        .cmt_valid(1'b0), .cmt_ready(b_cmt_ready), .cmt_prdt(1'b0), .cmt_rslv(1'b0),
        .cmt_pc(32'h0), .bht_wb_valid(b_wb_valid), .bht_wb_ready(1'b0),
        .bht_wb_mis(b_wb_mis), .bht_wb_prdt(b_wb_prdt), .bht_wb_rslv(b_wb_rslv),
        .bht_wb_pc(b_wb_pc), .cnt_clr(1'b0), .cnt_sel(1'b0), .cnt_rd(b_cnt_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fexp_t mk(input logic [1:0] src, input logic [1:0] ack);
        fexp_t e;
        int i;
        i = src[1] ? 1 : 0;
        e.src = src;
        e.ack = ack;
        e.op1 = 32'h1111_0000 + 32'(i);
        e.op2 = 32'h2222_0000 + 32'(i);
        e.pc  = 32'h8000_0100 + 32'(4 * i);
        return e;
    endfunction

    task automatic exp_a(input logic [1:0] src, input logic [1:0] ack);
        qa.push_back(mk(src, ack));
    endtask

    task automatic exp_b(input logic [1:0] src, input logic [1:0] ack);
        qb.push_back(mk(src, ack));
    endtask

    task automatic push_rec(input logic p, input logic r, input logic [31:0] pc, input bit track);
        bht_rec_t rec;
        cmt_valid = 1'b1;
        cmt_prdt  = p;
        cmt_rslv  = r;
        cmt_pc    = pc;
        rec.prdt  = p;
        rec.rslv  = r;
        rec.pc    = pc;
        if (track) qbht.push_back(rec);
    endtask

    task automatic rd_cnt(input logic sel, input logic [1:0] exp);
        cnt_sel = sel;
        tick();
        tick();
        #1 chk($sformatf("cnt_rd[%0d]", sel), 32'(cnt_rd), 32'(exp));
    endtask

    // Flush-port monitors: one popped expectation per cycle with a request.
    always @(negedge clk) begin
        fexp_t e;
        if (pipe_flush_req) begin
            if (qa.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL a_unexpected: got req src=%b, expected no request", pipe_flush_src);
            end else begin
                e = qa.pop_front();
                chk("a_src",   32'(pipe_flush_src), 32'(e.src));
                chk("a_ack",   32'(src_ack),        32'(e.ack));
                chk("a_pulse", 32'(flush_pulse),    32'(|e.ack));
                chk("a_op1",   pipe_flush_add_op1,  e.op1);
                chk("a_op2",   pipe_flush_add_op2,  e.op2);
                chk("a_pc",    pipe_flush_pc,       e.pc);
            end
        end else begin
            chk("a_idle_src",   32'(pipe_flush_src), 32'h0);
            chk("a_idle_ack",   32'(src_ack),        32'h0);
            chk("a_idle_pulse", 32'(flush_pulse),    32'h0);
        end
    end

    always @(negedge clk) begin
        fexp_t e;
        if (b_req) begin
            if (qb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_unexpected: got req src=%b, expected no request", b_src);
            end else begin
                e = qb.pop_front();
                chk("b_src", 32'(b_src),     32'(e.src));
                chk("b_ack", 32'(b_src_ack), 32'(e.ack));
                chk("b_op1", b_op1,          e.op1);
                chk("b_op2", b_op2,          e.op2);
                chk("b_pc",  b_pc,           e.pc);
            end
        end
    end

    always @(negedge clk) begin
        bht_rec_t e;
        if (bht_wb_valid && bht_wb_ready) begin
            if (qbht.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL bht_unexpected: got pc=%h, expected no record", bht_wb_pc);
            end else begin
                e = qbht.pop_front();
                chk("bht_pc",   bht_wb_pc,          e.pc);
                chk("bht_prdt", 32'(bht_wb_prdt),   32'(e.prdt));
                chk("bht_rslv", 32'(bht_wb_rslv),   32'(e.rslv));
                chk("bht_mis",  32'(bht_wb_mis),    32'(e.prdt ^ e.rslv));
            end
        end
    end

    initial begin
        rst = 1'b1; src_req = '0; src_req_b = '0; ack = 1'b0; ack_b = 1'b0;
        src_add_op1 = {32'h1111_0001, 32'h1111_0000};
        src_add_op2 = {32'h2222_0001, 32'h2222_0000};
        src_pc      = {32'h8000_0104, 32'h8000_0100};
        cmt_valid = 1'b0; cmt_prdt = 1'b0; cmt_rslv = 1'b0; cmt_pc = '0;
        bht_wb_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_req",       32'(pipe_flush_req), 32'h0);
        chk("rst_wb_valid",  32'(bht_wb_valid),   32'h0);
        chk("rst_cmt_ready", 32'(cmt_ready),      32'h1);
        chk("rst_cnt_rd",    32'(cnt_rd),         32'h0);

        // Both request with immediate ack: source 0 first, then source 1.
        tick(); src_req = 2'b11; ack = 1'b1; exp_a(2'b01, 2'b01);
        tick(); src_req = 2'b10;             exp_a(2'b10, 2'b10);
        tick(); src_req = 2'b00; ack = 1'b0;
        rd_cnt(1'b0, 2'd1);
        rd_cnt(1'b1, 2'd1);

        // Non-preemptive lock holds source 1 while source 0 rises.
        for (int k = 0; k < 3; k++) begin
            tick(); src_req = 2'b10; exp_a(2'b10, 2'b00);
        end
        tick(); src_req = 2'b11;  exp_a(2'b10, 2'b00);
        tick(); ack = 1'b1;       exp_a(2'b10, 2'b10);
        tick(); src_req = 2'b01;  exp_a(2'b01, 2'b01);
        tick(); src_req = 2'b00; ack = 1'b0;
        rd_cnt(1'b0, 2'd2);

        // Preemptive instance switches to source 0 as soon as it rises.
        for (int k = 0; k < 3; k++) begin
            tick(); src_req_b = 2'b10; exp_b(2'b10, 2'b00);
        end
        tick(); src_req_b = 2'b11;  exp_b(2'b01, 2'b00);
        tick(); ack_b = 1'b1;       exp_b(2'b01, 2'b01);
        tick(); src_req_b = 2'b10;  exp_b(2'b10, 2'b10);
        tick(); src_req_b = 2'b00; ack_b = 1'b0;

        // Counter saturation at 3, then clear beats a same-cycle flush.
        for (int k = 0; k < 5; k++) begin
            tick(); src_req = 2'b10; ack = 1'b1; exp_a(2'b10, 2'b10);
        end
        tick(); src_req = 2'b00; ack = 1'b0;
        rd_cnt(1'b1, 2'd3);
        tick(); src_req = 2'b10; ack = 1'b1; cnt_clr = 1'b1; exp_a(2'b10, 2'b10);
        tick(); src_req = 2'b00; ack = 1'b0; cnt_clr = 1'b0;
        rd_cnt(1'b1, 2'd0);
        rd_cnt(1'b0, 2'd0);

        // Fill the FIFO, reject a push while full, then drain in order.
        tick(); push_rec(1'b1, 1'b0, 32'h0000_1000, 1'b1); #1 chk("cmt_ready_0", 32'(cmt_ready), 32'h1);
        tick(); push_rec(1'b0, 1'b0, 32'h0000_1004, 1'b1); #1 chk("cmt_ready_1", 32'(cmt_ready), 32'h1);
        tick(); push_rec(1'b1, 1'b1, 32'h0000_1008, 1'b1); #1 chk("cmt_ready_2", 32'(cmt_ready), 32'h1);
        tick(); push_rec(1'b0, 1'b1, 32'h0000_100C, 1'b1); #1 chk("cmt_ready_3", 32'(cmt_ready), 32'h1);
        tick(); push_rec(1'b0, 1'b0, 32'hDEAD_0000, 1'b0);
        #1;
        chk("full_cmt_ready", 32'(cmt_ready),    32'h0);
        chk("full_wb_valid",  32'(bht_wb_valid), 32'h1);
        chk("full_head_pc",   bht_wb_pc,         32'h0000_1000);
        chk("full_head_mis",  32'(bht_wb_mis),   32'h1);
        tick(); cmt_valid = 1'b0; bht_wb_ready = 1'b1;
        repeat (4) tick();
        #1 chk("drained_valid", 32'(bht_wb_valid), 32'h0);

        // Simultaneous push and pop keeps occupancy at one.
        tick(); bht_wb_ready = 1'b0; push_rec(1'b1, 1'b0, 32'h0000_2000, 1'b1);
        tick(); bht_wb_ready = 1'b1; push_rec(1'b0, 1'b1, 32'h0000_2004, 1'b1);
        tick(); cmt_valid = 1'b0;
        #1;
        chk("pp_valid",   32'(bht_wb_valid), 32'h1);
        chk("pp_head_pc", bht_wb_pc,         32'h0000_2004);
        tick();
        #1 chk("pp_empty", 32'(bht_wb_valid), 32'h0);
        bht_wb_ready = 1'b0;

        // Reset while locked with two records queued.
        tick(); push_rec(1'b1, 1'b0, 32'h0000_3000, 1'b0);
        tick(); push_rec(1'b0, 1'b1, 32'h0000_3004, 1'b0);
        tick(); cmt_valid = 1'b0; src_req = 2'b10; ack = 1'b0; exp_a(2'b10, 2'b00);
        tick(); rst = 1'b1; exp_a(2'b10, 2'b00);
        tick(); rst = 1'b0; src_req = 2'b11; ack = 1'b1; exp_a(2'b01, 2'b01);
        #1;
        chk("mid_rst_wb_valid",  32'(bht_wb_valid), 32'h0);
        chk("mid_rst_cmt_ready", 32'(cmt_ready),    32'h1);
        tick(); src_req = 2'b00; ack = 1'b0;
        #1 chk("mid_rst_req", 32'(pipe_flush_req), 32'h0);
        repeat (2) tick();

        while (qa.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL a_missing: got no request, expected src=%b", qa[0].src);
            void'(qa.pop_front());
        end
        while (qb.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL b_missing: got no request, expected src=%b", qb[0].src);
            void'(qb.pop_front());
        end
        while (qbht.size() > 0) begin
            n_vec++; n_err++;
            $display("FAIL bht_missing: got no pop, expected pc=%h", qbht[0].pc);
            void'(qbht.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
